// File: rtl/anton_neopixel_bus_arbiter.sv
// Two-port arbiter onto the neopixel register bus (round-robin or fixed priority, per-transfer timeout).
// Bus driven the cycle after a grant, ack the cycle after busReady/timeout; requesters stall on reqN until ackN.
module anton_neopixel_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          FIXED_PRIORITY = 1'b0
) (
    input  logic        apbPclk,
    input  logic        apbPresern,
    input  logic        req0,
    input  logic        write0,
    input  logic [17:0] addr0,
    input  logic [7:0]  wdata0,
    output logic [7:0]  rdata0,
    output logic        ack0,
    output logic        err0,
    input  logic        req1,
    input  logic        write1,
    input  logic [17:0] addr1,
    input  logic [7:0]  wdata1,
    output logic [7:0]  rdata1,
    output logic        ack1,
    output logic        err1,
    output logic [17:0] busAddr,
    output logic [7:0]  busDataIn,
    output logic        busWrite,
    output logic        busRead,
    input  logic [7:0]  busDataOut,
    input  logic        busReady,
    output logic [1:0]  grant
);
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} arbState;

    arbState     state;
    arbState     stateNext;
    logic        lastGrant;
    logic        owner;
    logic        pick;
    logic        timedOut;
    logic        finish;
    logic [15:0] waitCount;

    always_comb begin
        pick = req1 && !req0;
        if (req0 && req1) begin
            pick = FIXED_PRIORITY ? 1'b0 : !lastGrant;
        end
        // A ready arriving in the limit cycle still counts as a completion.
        timedOut  = (waitCount == TIMEOUT_LIMIT) && !busReady;
        finish    = busReady || timedOut;
        stateNext = state;
        case (state)
            IDLE:    if (req0 || req1) stateNext = BUSY;
            BUSY:    if (finish) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge apbPclk) begin
        if (!apbPresern) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge apbPclk) begin
        if (!apbPresern) begin
            lastGrant <= 1'b1;
            owner     <= 1'b0;
            grant     <= 2'b00;
            waitCount <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            busAddr   <= '0;
            busDataIn <= '0;
            busWrite  <= 1'b0;
            busRead   <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner     <= pick;
                        grant     <= pick ? 2'b10 : 2'b01;
                        busAddr   <= pick ? addr1 : addr0;
                        busDataIn <= pick ? wdata1 : wdata0;
                        busWrite  <= pick ? write1 : write0;
                        busRead   <= pick ? !write1 : !write0;
                        waitCount <= '0;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        grant     <= 2'b00;
                        busAddr   <= '0;
                        busDataIn <= '0;
                        busWrite  <= 1'b0;
                        busRead   <= 1'b0;
                        ack0      <= !owner;
                        ack1      <= owner;
                        err0      <= timedOut && !owner;
                        err1      <= timedOut && owner;
                        // busRead still holds the latched direction here; writes keep rdata.
                        if (timedOut || busRead) begin
                            if (owner) begin
                                rdata1 <= timedOut ? 8'h00 : busDataOut;
                            end else begin
                                rdata0 <= timedOut ? 8'h00 : busDataOut;
                            end
                        end
                    end else begin
                        waitCount <= waitCount + 16'd1;
                    end
                end
                DONE: begin
                    lastGrant <= owner;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_anton_neopixel_bus_arbiter.sv
// Randomized and directed bench for the two-port neopixel bus arbiter, one round-robin and one fixed-priority instance.
`timescale 1ns/1ps
module tb_anton_neopixel_bus_arbiter;
    localparam int T = 4;

    logic        apbPclk = 1'b0;
    logic        apbPresern;
    logic        req0, write0, req1, write1;
    logic [17:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic [7:0]  busDataOut;
    logic        busReady;
    logic        sel;

    logic [7:0]  aRdata0, aRdata1, bRdata0, bRdata1;
    logic        aAck0, aAck1, aErr0, aErr1, bAck0, bAck1, bErr0, bErr1;
    logic [17:0] aBusAddr, bBusAddr;
    logic [7:0]  aBusDataIn, bBusDataIn;
    logic        aBusWrite, aBusRead, bBusWrite, bBusRead;
    logic [1:0]  aGrant, bGrant;

    logic [7:0]  rdata0, rdata1;
    logic        ack0, ack1, err0, err1;
    logic [17:0] busAddr;
    logic [7:0]  busDataIn;
    logic        busWrite, busRead;
    logic [1:0]  grant;

    int total = 0;
    int bad = 0;
    int conflictCnt = 0;

    typedef struct {
        bit          started;
        int          waitCycles;
        int          strobeCycles;
        logic [1:0]  grant;
        logic [17:0] addr;
        logic [7:0]  wdata;
        logic        wr;
        logic        ack0;
        logic        ack1;
        logic        err0;
        logic        err1;
        logic [7:0]  rdata0;
        logic [7:0]  rdata1;
    } xfer_t;

    always #5 apbPclk = ~apbPclk;

    anton_neopixel_bus_arbiter #(.TIMEOUT_CYCLES(T), .FIXED_PRIORITY(1'b0)) dutRr (
        .apbPclk(apbPclk), .apbPresern(apbPresern),
        .req0(req0), .write0(write0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(aRdata0), .ack0(aAck0), .err0(aErr0),
        .req1(req1), .write1(write1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(aRdata1), .ack1(aAck1), .err1(aErr1),
        .busAddr(aBusAddr), .busDataIn(aBusDataIn), .busWrite(aBusWrite), .busRead(aBusRead),
        .busDataOut(busDataOut), .busReady(busReady), .grant(aGrant)
    );

    anton_neopixel_bus_arbiter #(.TIMEOUT_CYCLES(T), .FIXED_PRIORITY(1'b1)) dutFixed (
        .apbPclk(apbPclk), .apbPresern(apbPresern),
        .req0(req0), .write0(write0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(bRdata0), .ack0(bAck0), .err0(bErr0),
        .req1(req1), .write1(write1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(bRdata1), .ack1(bAck1), .err1(bErr1),
        .busAddr(bBusAddr), .busDataIn(bBusDataIn), .busWrite(bBusWrite), .busRead(bBusRead),
        .busDataOut(busDataOut), .busReady(busReady), .grant(bGrant)
    );

    assign rdata0    = sel ? bRdata0    : aRdata0;
    assign rdata1    = sel ? bRdata1    : aRdata1;
    assign ack0      = sel ? bAck0      : aAck0;
    assign ack1      = sel ? bAck1      : aAck1;
    assign err0      = sel ? bErr0      : aErr0;
    assign err1      = sel ? bErr1      : aErr1;
    assign busAddr   = sel ? bBusAddr   : aBusAddr;
    assign busDataIn = sel ? bBusDataIn : aBusDataIn;
    assign busWrite  = sel ? bBusWrite  : aBusWrite;
    assign busRead   = sel ? bBusRead   : aBusRead;
    assign grant     = sel ? bGrant     : aGrant;

    always @(negedge apbPclk) begin
        if (apbPresern === 1'b1 &&
            (((ack0 & ack1) === 1'b1) || grant === 2'b11 || ((busWrite & busRead) === 1'b1)))
            conflictCnt = conflictCnt + 1;
    end

    task automatic tick();
        @(posedge apbPclk);
        #1;
    endtask

    task automatic do_reset();
        apbPresern = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        busReady = 1'b0;
        tick();
        tick();
        apbPresern = 1'b1;
    endtask

    // Waits for the bus to start, plays the slave (ready in bus cycle 'lat'), returns what was seen.
    task automatic do_xfer(input int lat, input logic [7:0] rd, input int dropAt, output xfer_t o);
        int k;
        o = '{default: 0};
        k = 0;
        while (!(busWrite || busRead) && o.waitCycles < 20) begin
            tick();
            o.waitCycles++;
        end
        if (!(busWrite || busRead)) return;
        o.started = 1'b1;
        o.grant   = grant;
        o.addr    = busAddr;
        o.wdata   = busDataIn;
        o.wr      = busWrite;
        while ((busWrite || busRead) && k < 100) begin
            o.strobeCycles++;
            if (k == dropAt) begin
                if (grant[0]) req0 = 1'b0;
                if (grant[1]) req1 = 1'b0;
            end
            busReady   = (k == lat);
            busDataOut = (k == lat) ? rd : 8'($urandom);
            tick();
            k++;
        end
        busReady = 1'b0;
        o.ack0   = ack0;
        o.ack1   = ack1;
        o.err0   = err0;
        o.err1   = err1;
        o.rdata0 = rdata0;
        o.rdata1 = rdata1;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        total++;
        if ({ack0, ack1, err0, err1, busWrite, busRead, grant} !== 8'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b expected 00000000", {ack0, ack1, err0, err1, busWrite, busRead, grant});
        end
        total++;
        if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
            bad++;
            $display("FAIL reset_rdata: got %h/%h expected 00/00", rdata0, rdata1);
        end
        total++;
        if (busAddr !== 18'h0 || busDataIn !== 8'h00) begin
            bad++;
            $display("FAIL reset_bus: got %h/%h expected 0/0", busAddr, busDataIn);
        end
    endtask

    task automatic test_single_write();
        xfer_t o;
        req0 = 1'b1; write0 = 1'b1; addr0 = 18'h00010; wdata0 = 8'hA5;
        do_xfer(2, 8'h00, -1, o);
        total++;
        if (!o.started || o.waitCycles != 1) begin
            bad++;
            $display("FAIL sw_latency: got started=%0d wait=%0d expected 1/1", o.started, o.waitCycles);
        end
        total++;
        if (o.grant !== 2'b01 || o.addr !== 18'h00010 || o.wdata !== 8'hA5 || o.wr !== 1'b1) begin
            bad++;
            $display("FAIL sw_bus: got g=%b a=%h d=%h w=%b expected 01/00010/a5/1", o.grant, o.addr, o.wdata, o.wr);
        end
        total++;
        if (o.strobeCycles != 3) begin
            bad++;
            $display("FAIL sw_strobe_len: got %0d expected 3", o.strobeCycles);
        end
        total++;
        if ({o.ack1, o.ack0, o.err0} !== 3'b010 || o.rdata0 !== 8'h00) begin
            bad++;
            $display("FAIL sw_ack: got ack=%b%b err=%b rdata=%h expected 01/0/00", o.ack1, o.ack0, o.err0, o.rdata0);
        end
        req0 = 1'b0;
        tick();
        total++;
        if (ack0 !== 1'b0 || grant !== 2'b00) begin
            bad++;
            $display("FAIL sw_ack_pulse: got ack0=%b grant=%b expected 0/00", ack0, grant);
        end
    endtask

    task automatic test_tie_reads();
        xfer_t o1, o2;
        do_reset();
        req0 = 1'b1; write0 = 1'b0; addr0 = 18'h00100;
        req1 = 1'b1; write1 = 1'b0; addr1 = 18'h20004;
        do_xfer(1, 8'h3C, -1, o1);
        req0 = 1'b0;
        do_xfer(0, 8'h7E, -1, o2);
        req1 = 1'b0;
        total++;
        if (o1.grant !== 2'b01 || o1.addr !== 18'h00100 || o1.wr !== 1'b0) begin
            bad++;
            $display("FAIL tie_first: got g=%b a=%h w=%b expected 01/00100/0", o1.grant, o1.addr, o1.wr);
        end
        total++;
        if ({o1.ack1, o1.ack0} !== 2'b01 || o1.rdata0 !== 8'h3C) begin
            bad++;
            $display("FAIL tie_rdata0: got ack=%b%b rdata0=%h expected 01/3c", o1.ack1, o1.ack0, o1.rdata0);
        end
        total++;
        if (o2.grant !== 2'b10 || o2.addr !== 18'h20004) begin
            bad++;
            $display("FAIL tie_second: got g=%b a=%h expected 10/20004", o2.grant, o2.addr);
        end
        total++;
        if ({o2.ack1, o2.ack0} !== 2'b10 || o2.rdata1 !== 8'h7E || o2.rdata0 !== 8'h3C) begin
            bad++;
            $display("FAIL tie_rdata1: got ack=%b%b rd1=%h rd0=%h expected 10/7e/3c", o2.ack1, o2.ack0, o2.rdata1, o2.rdata0);
        end
        // Strobes are low for the ack cycle and the following idle cycle.
        total++;
        if (o2.waitCycles != 2) begin
            bad++;
            $display("FAIL tie_gap: got %0d expected 2", o2.waitCycles);
        end
    endtask

    task automatic test_timeout();
        xfer_t o;
        req0 = 1'b1; write0 = 1'b0; addr0 = 18'h10000;
        do_xfer(1000, 8'hFF, -1, o);
        total++;
        if (o.strobeCycles != T + 1) begin
            bad++;
            $display("FAIL to_len: got %0d expected %0d", o.strobeCycles, T + 1);
        end
        total++;
        if ({o.ack1, o.ack0, o.err1, o.err0} !== 4'b0101 || o.rdata0 !== 8'h00) begin
            bad++;
            $display("FAIL to_ack: got ack=%b%b err=%b%b rd0=%h expected 01/01/00", o.ack1, o.ack0, o.err1, o.err0, o.rdata0);
        end
        total++;
        if (busWrite !== 1'b0 || busRead !== 1'b0) begin
            bad++;
            $display("FAIL to_strobes: got w=%b r=%b expected 0/0", busWrite, busRead);
        end
        req0 = 1'b0;
        tick();
        total++;
        if (err0 !== 1'b0 || ack0 !== 1'b0) begin
            bad++;
            $display("FAIL to_err_pulse: got err0=%b ack0=%b expected 0/0", err0, ack0);
        end
    endtask

    task automatic test_ready_at_limit();
        xfer_t o;
        req1 = 1'b1; write1 = 1'b0; addr1 = 18'h3FFFF;
        do_xfer(T, 8'h5A, -1, o);
        req1 = 1'b0;
        total++;
        if (o.strobeCycles != T + 1) begin
            bad++;
            $display("FAIL lim_len: got %0d expected %0d", o.strobeCycles, T + 1);
        end
        total++;
        if ({o.ack1, o.ack0, o.err1, o.err0} !== 4'b1000 || o.rdata1 !== 8'h5A) begin
            bad++;
            $display("FAIL lim_ack: got ack=%b%b err=%b%b rd1=%h expected 10/00/5a", o.ack1, o.ack0, o.err1, o.err0, o.rdata1);
        end
    endtask

    task automatic test_alternation();
        xfer_t o;
        logic [1:0] expG;
        for (int pass = 0; pass < 2; pass++) begin
            sel = (pass == 1);
            do_reset();
            req0 = 1'b1; write0 = 1'b0; addr0 = 18'h00004;
            req1 = 1'b1; write1 = 1'b0; addr1 = 18'h00008;
            for (int i = 0; i < 8; i++) begin
                do_xfer($urandom_range(0, 2), 8'($urandom), -1, o);
                expG = (pass == 1 || i % 2 == 0) ? 2'b01 : 2'b10;
                total++;
                if (o.grant !== expG) begin
                    bad++;
                    $display("FAIL alt_grant fixed=%0d i=%0d: got %b expected %b", pass, i, o.grant, expG);
                end
            end
        end
        sel = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_in_busy();
        xfer_t o;
        int k;
        do_reset();
        req0 = 1'b1; write0 = 1'b1; addr0 = 18'h00200; wdata0 = 8'h33;
        do_xfer(0, 8'h00, -1, o);
        k = 0;
        while (!(busWrite || busRead) && k < 10) begin
            tick();
            k++;
        end
        total++;
        if (busWrite !== 1'b1) begin
            bad++;
            $display("FAIL rib_start: got busWrite=%b expected 1", busWrite);
        end
        req1 = 1'b1; write1 = 1'b0;
        apbPresern = 1'b0;
        tick();
        total++;
        if ({ack0, ack1, err0, err1, busWrite, busRead, grant} !== 8'b0) begin
            bad++;
            $display("FAIL rib_ctrl: got %b expected 00000000", {ack0, ack1, err0, err1, busWrite, busRead, grant});
        end
        total++;
        if (busAddr !== 18'h0 || busDataIn !== 8'h00) begin
            bad++;
            $display("FAIL rib_bus: got %h/%h expected 0/0", busAddr, busDataIn);
        end
        apbPresern = 1'b1;
        do_xfer(0, 8'h11, -1, o);
        req0 = 1'b0;
        req1 = 1'b0;
        total++;
        if (o.grant !== 2'b01 || o.ack0 !== 1'b1) begin
            bad++;
            $display("FAIL rib_tie: got g=%b ack0=%b expected 01/1", o.grant, o.ack0);
        end
    endtask

    // Reference: each port holds one pending transaction; a tie goes to the port not served last.
    task automatic test_random();
        bit          pend[2];
        logic        mWr[2];
        logic [17:0] mAd[2];
        logic [7:0]  mWd[2];
        logic [7:0]  mRd[2];
        bit          mLast, w, tmo;
        int          lat, dropAt, r, c0;
        logic [7:0]  rd, expRd;
        logic [1:0]  oneHot;
        xfer_t       o;
        sel = 1'b0;
        do_reset();
        c0 = conflictCnt;
        mLast = 1'b1;
        pend[0] = 0; pend[1] = 0;
        mRd[0] = 8'h00; mRd[1] = 8'h00;
        for (int n = 0; n < 60; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p] = 1'b1;
                    mWr[p]  = 1'($urandom);
                    mAd[p]  = 18'($urandom);
                    mWd[p]  = 8'($urandom);
                end
            end
            if (!pend[0] && !pend[1]) begin
                w = 1'($urandom);
                pend[w] = 1'b1;
                mWr[w]  = 1'($urandom);
                mAd[w]  = 18'($urandom);
                mWd[w]  = 8'($urandom);
            end
            req0 = pend[0]; write0 = mWr[0]; addr0 = mAd[0]; wdata0 = mWd[0];
            req1 = pend[1]; write1 = mWr[1]; addr1 = mAd[1]; wdata1 = mWd[1];
            w = (pend[0] && pend[1]) ? !mLast : pend[1];
            oneHot = w ? 2'b10 : 2'b01;
            r = $urandom_range(0, 9);
            lat = (r < 6) ? r % 4 : ((r < 8) ? T : T + 5);
            tmo = (lat > T);
            rd = 8'($urandom);
            dropAt = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1;
            do_xfer(lat, rd, dropAt, o);
            expRd = tmo ? 8'h00 : (mWr[w] ? mRd[w] : rd);
            total++;
            if (!o.started || o.grant !== oneHot) begin
                bad++;
                $display("FAIL rnd_grant n=%0d: got started=%0d g=%b expected 1/%b", n, o.started, o.grant, oneHot);
            end
            total++;
            if (o.addr !== mAd[w] || o.wdata !== mWd[w] || o.wr !== mWr[w]) begin
                bad++;
                $display("FAIL rnd_bus n=%0d: got %h/%h/%b expected %h/%h/%b", n, o.addr, o.wdata, o.wr, mAd[w], mWd[w], mWr[w]);
            end
            total++;
            if (o.strobeCycles != (tmo ? T + 1 : lat + 1)) begin
                bad++;
                $display("FAIL rnd_len n=%0d: got %0d expected %0d", n, o.strobeCycles, tmo ? T + 1 : lat + 1);
            end
            total++;
            if ({o.ack1, o.ack0} !== oneHot || {o.err1, o.err0} !== (tmo ? oneHot : 2'b00)) begin
                bad++;
                $display("FAIL rnd_ack n=%0d: got ack=%b%b err=%b%b expected %b/%b", n, o.ack1, o.ack0, o.err1, o.err0, oneHot, tmo ? oneHot : 2'b00);
            end
            total++;
            if ((w ? o.rdata1 : o.rdata0) !== expRd || (w ? o.rdata0 : o.rdata1) !== mRd[w ? 0 : 1]) begin
                bad++;
                $display("FAIL rnd_rdata n=%0d: got %h/%h expected %h/%h", n, o.rdata0, o.rdata1, w ? mRd[0] : expRd, w ? expRd : mRd[1]);
            end
            mRd[w] = expRd;
            mLast = w;
            pend[w] = 1'b0;
            if (w) req1 = 1'b0; else req0 = 1'b0;
            if (pend[w ? 0 : 1]) begin
                if ($urandom_range(0, 1) == 1) tick();
            end else begin
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        total++;
        if (conflictCnt != c0) begin
            bad++;
            $display("FAIL rnd_exclusive: got %0d conflict cycles expected 0", conflictCnt - c0);
        end
    endtask

    initial begin
        sel = 1'b0;
        apbPresern = 1'b0;
        req0 = 1'b0; write0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; write1 = 1'b0; addr1 = '0; wdata1 = '0;
        busDataOut = '0;
        busReady = 1'b0;
        test_reset();
        test_single_write();
        test_tie_reads();
        test_timeout();
        test_ready_at_limit();
        test_alternation();
        test_reset_in_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/anton_neopixel_bus_arbiter.md
ANTON_NEOPIXEL_BUS_ARBITER -- requirements
Module: anton_neopixel_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: the maximum number of cycles a granted transaction waits for busReady before it is aborted; legal range is 1..65535.
REQ-002 Parameter FIXED_PRIORITY, default 0: 0 selects round-robin arbitration; 1 makes port 0 always win.
REQ-003 apbPclk  input  1  single clock; every flop in the block is clocked on its rising edge.
REQ-004 apbPresern  input  1  reset, synchronous and active-low.
REQ-005 reqN  input  1  (N = 0,1) port N transaction request; held high until ackN.
REQ-006 writeN  input  1  port N direction: 1 = write, 0 = read; held stable while reqN is high.
REQ-007 addrN  input  18  port N byte address (control/delta/virtual/raw region map); held stable while reqN is high.
REQ-008 wdataN  input  8  port N write data; held stable while reqN is high.
REQ-009 rdataN  output  8  port N read data; valid in the ackN cycle.
REQ-010 ackN  output  1  port N one-cycle completion pulse.
REQ-011 errN  output  1  port N timeout flag; valid only in the ackN cycle.
REQ-012 busAddr  output  18  address to the neopixel module.
REQ-013 busDataIn  output  8  write data to the neopixel module.
REQ-014 busWrite  output  1  write strobe to the neopixel module.
REQ-015 busRead  output  1  read strobe to the neopixel module.
REQ-016 busDataOut  input  8  read data from the neopixel module.
REQ-017 busReady  input  1  transfer-complete signal from the neopixel module.
REQ-018 grant  output  2  one-hot indicator of the currently owning port; 2'b00 when idle.

Function
REQ-019 The FSM has exactly three states: IDLE, BUSY and DONE.
REQ-020 IDLE: if any reqN is sampled high, the arbiter latches the winner's addr, wdata and write into registers, sets grant and enters BUSY on the next cycle; with no request it stays in IDLE.
REQ-021 Round-robin: when both requests are high, the port not granted last wins; the last-grant register resets to port 1, so port 0 wins the first tie.
REQ-022 FIXED_PRIORITY=1: port 0 wins every tie; the last-grant register is ignored.
REQ-023 Bus outputs are registered: during BUSY, busAddr and busDataIn carry the latched values, busWrite = latched write and busRead = !latched write; outside BUSY, busWrite, busRead, busAddr and busDataIn are all 0.
REQ-024 BUSY: when busReady is sampled high, the arbiter captures busDataOut into the winner's rdata (reads only) and enters DONE.
REQ-025 A write leaves rdataN unchanged.
REQ-026 DONE lasts one cycle: ackN = 1 for the winner only, grant returns to 2'b00, the last-grant register updates, and the FSM returns to IDLE.
REQ-027 Latency: a request sampled in IDLE at edge n drives the bus at cycles n+1 and after, and busReady sampled at edge m gives ack at cycle m+1. The next grant can occur at edge m+2 at the earliest, so there is always at least one idle bus cycle between transfers.
REQ-028 Timeout counter: 16 bits, cleared on entry to BUSY, and incremented each BUSY cycle while busReady is low.
REQ-029 If the counter reaches TIMEOUT_CYCLES with busReady still low, the arbiter enters DONE with errN = 1 and rdataN = 0.
REQ-030 If busReady is high in the same cycle the count hits TIMEOUT_CYCLES, the completion wins and err stays 0.
REQ-031 A reqN that drops before ackN does not abort the transfer, which completes normally.
REQ-032 A requester that raises reqN again in the cycle after its ack is treated as a new request.
REQ-033 ack0 and ack1 are never high together, and grant is never 2'b11.
REQ-034 busWrite and busRead are never high together.

Reset
REQ-035 When apbPresern is low at a clock edge, the next state is IDLE and the following are all 0: grant, ackN, errN, rdataN, busWrite, busRead, busAddr, busDataIn and the timeout counter; the last-grant register is set to port 1.
REQ-036 A reset during BUSY abandons the transfer with no ack issued; both bus strobes are low from the cycle after the reset edge.

Verification
REQ-037 Single write on port 0 (addr 0x00010, wdata 0xA5), busReady after 3 cycles -> busWrite high for 3 cycles with busAddr=0x00010 and busDataIn=0xA5, then ack0 one cycle later with err0=0.
REQ-038 Both ports request reads simultaneously from reset, with busDataOut=0x3C then 0x7E -> port 0 served first with rdata0=0x3C, port 1 next with rdata1=0x7E, and exactly one idle bus cycle between the two transfers.
REQ-039 Both ports request continuously for 8 transfers -> grants alternate 0,1,0,1...; with FIXED_PRIORITY=1, all 8 go to port 0.
REQ-040 TIMEOUT_CYCLES=4 and busReady never asserted -> ack for the winner with err=1 and rdata=0, and the bus strobes deassert.
REQ-041 busReady asserted in the same cycle the count reaches TIMEOUT_CYCLES -> normal ack with err=0 and the captured data.
REQ-042 apbPresern pulled low during BUSY -> no ack, all outputs 0 the next cycle, and port 0 wins the next tie.
